unidade_controle: RTL

//  Multi-cycle control unit for the 16-bit accumulator datapath; sits directly upstream of the ALU.

---
 rtl/unidade_controle.sv | 247 ++++++++++++++++++++++++
 1 files changed

// File: rtl/unidade_controle.sv
// Multi-cycle fetch/decode/execute control unit for the 16-bit accumulator datapath.
// Optional indirect addressing (states I0/I1) is enabled by defining CU_INDIRECT_EN.
module unidade_controle #(
  parameter int MEM_WAIT = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] opcode,
  input  logic       indireto,
  input  logic       N,
  input  logic       Z,
  input  logic       retomar,
  output logic [2:0] sel_ula,
  output logic       carga_rem,
  output logic       sel_rem,
  output logic       mem_read,
  output logic       mem_write,
  output logic       carga_rdm,
  output logic       carga_ri,
  output logic       carga_pc,
  output logic       inc_pc,
  output logic       carga_ac,
  output logic       carga_nz,
  output logic       halted,
  output logic [3:0] estado
);

  localparam int CW = (MEM_WAIT < 1) ? 1 : $clog2(MEM_WAIT + 1);
  localparam logic [CW-1:0] LAST = CW'(MEM_WAIT - 1);

  typedef enum logic [3:0] {
    F0   = 4'd0,
    F1   = 4'd1,
    F2   = 4'd2,
    DEC  = 4'd3,
    A0   = 4'd4,
    A1   = 4'd5,
    U    = 4'd6,
    W    = 4'd7,
    J    = 4'd8,
    HALT = 4'd9
`ifdef CU_INDIRECT_EN
    ,
    I0   = 4'd10,
    I1   = 4'd11
`endif
  } state_t;

  state_t          state_r;
  state_t          nxt_s;
  logic [CW-1:0]   cnt_r;
  logic [CW-1:0]   nxt_cnt_s;
  logic            last_s;
  logic            nlast_s;
  logic            wait_st_s;
  logic            jump_s;

  logic [2:0] sel_ula_s;
  logic       carga_rem_s, sel_rem_s, mem_read_s, mem_write_s, carga_rdm_s;
  logic       carga_ri_s, carga_pc_s, inc_pc_s, carga_ac_s, carga_nz_s, halted_s;

`ifndef CU_INDIRECT_EN
  logic unused_indireto_s;
  assign unused_indireto_s = indireto;
`endif

  function automatic logic [2:0] alu_sel(input logic [3:0] op);
    logic [2:0] s;
    case (op)
      4'h2:    s = 3'b111;
      4'h3:    s = 3'b000;
      4'h4:    s = 3'b001;
      4'h5:    s = 3'b010;
      4'h6:    s = 3'b011;
      4'h7:    s = 3'b100;
      4'hB:    s = 3'b101;
      4'hC:    s = 3'b110;
      default: s = 3'b000;
    endcase
    return s;
  endfunction

  assign last_s  = (cnt_r == LAST);
  assign nlast_s = (nxt_cnt_s == LAST);
  assign jump_s  = (opcode == 4'h8) || ((opcode == 4'h9) && N) || ((opcode == 4'hA) && Z);

  // Next-state selection and wait-counter update.
  always_comb begin
    nxt_s     = state_r;
    wait_st_s = 1'b0;
    case (state_r)
      F0: nxt_s = F1;
      F1: begin
        wait_st_s = 1'b1;
        if (last_s) nxt_s = F2;
        else        nxt_s = F1;
      end
      F2:  nxt_s = DEC;
      DEC: begin
        case (opcode)
          4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6: begin
`ifdef CU_INDIRECT_EN
            if (indireto) nxt_s = I0;
            else          nxt_s = A0;
`else
            nxt_s = A0;
`endif
          end
          4'h7, 4'hB, 4'hC: nxt_s = U;
          4'h8, 4'h9, 4'hA: begin
`ifdef CU_INDIRECT_EN
            if (indireto) nxt_s = I0;
            else          nxt_s = J;
`else
            nxt_s = J;
`endif
          end
          4'hF:    nxt_s = HALT;
          default: nxt_s = F0;
        endcase
      end
      A0: begin
        if (opcode == 4'h1) nxt_s = W;
        else                nxt_s = A1;
      end
      A1: begin
        wait_st_s = 1'b1;
        if (last_s) nxt_s = U;
        else        nxt_s = A1;
      end
      U: nxt_s = F0;
      W: begin
        wait_st_s = 1'b1;
        if (last_s) nxt_s = F0;
        else        nxt_s = W;
      end
      J: nxt_s = F0;
      HALT: begin
        if (retomar) nxt_s = F0;
        else         nxt_s = HALT;
      end
`ifdef CU_INDIRECT_EN
      I0: nxt_s = I1;
      I1: begin
        wait_st_s = 1'b1;
        if (!last_s)                                           nxt_s = I1;
        else if ((opcode >= 4'h8) && (opcode <= 4'hA))         nxt_s = J;
        else                                                   nxt_s = A0;
      end
`endif
      default: nxt_s = F0;
    endcase

    if ((nxt_s == state_r) && wait_st_s) nxt_cnt_s = cnt_r + CW'(1);
    else                                 nxt_cnt_s = '0;
  end

  // Output decode for the state being entered, so the registered strobes line up with estado.
  always_comb begin
    sel_ula_s   = 3'b000;
    carga_rem_s = 1'b0;
    sel_rem_s   = 1'b0;
    mem_read_s  = 1'b0;
    mem_write_s = 1'b0;
    carga_rdm_s = 1'b0;
    carga_ri_s  = 1'b0;
    carga_pc_s  = 1'b0;
    inc_pc_s    = 1'b0;
    carga_ac_s  = 1'b0;
    carga_nz_s  = 1'b0;
    halted_s    = 1'b0;
    case (nxt_s)
      F0: carga_rem_s = 1'b1;
      F1: begin
        mem_read_s  = 1'b1;
        carga_rdm_s = nlast_s;
        inc_pc_s    = nlast_s;
      end
      F2: carga_ri_s = 1'b1;
      A0: begin
        carga_rem_s = 1'b1;
        sel_rem_s   = 1'b1;
      end
      A1: begin
        mem_read_s  = 1'b1;
        carga_rdm_s = nlast_s;
      end
      U: begin
        sel_ula_s  = alu_sel(opcode);
        carga_ac_s = 1'b1;
        carga_nz_s = 1'b1;
      end
      W:    mem_write_s = 1'b1;
      J:    carga_pc_s  = jump_s;
      HALT: halted_s    = 1'b1;
`ifdef CU_INDIRECT_EN
      I0: begin
        carga_rem_s = 1'b1;
        sel_rem_s   = 1'b1;
      end
      I1: begin
        mem_read_s  = 1'b1;
        carga_rdm_s = nlast_s;
      end
`endif
      default: carga_rem_s = 1'b0;
    endcase
  end

  // State, counter and output registers; the first F0 after reset is silent since REM and PC both reset to 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r   <= F0;
      cnt_r     <= '0;
      sel_ula   <= 3'b000;
      carga_rem <= 1'b0;
      sel_rem   <= 1'b0;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      carga_rdm <= 1'b0;
      carga_ri  <= 1'b0;
      carga_pc  <= 1'b0;
      inc_pc    <= 1'b0;
      carga_ac  <= 1'b0;
      carga_nz  <= 1'b0;
      halted    <= 1'b0;
      estado    <= 4'd0;
    end else begin
      state_r   <= nxt_s;
      cnt_r     <= nxt_cnt_s;
      sel_ula   <= sel_ula_s;
      carga_rem <= carga_rem_s;
      sel_rem   <= sel_rem_s;
      mem_read  <= mem_read_s;
      mem_write <= mem_write_s;
      carga_rdm <= carga_rdm_s;
      carga_ri  <= carga_ri_s;
      carga_pc  <= carga_pc_s;
      inc_pc    <= inc_pc_s;
      carga_ac  <= carga_ac_s;
      carga_nz  <= carga_nz_s;
      halted    <= halted_s;
      estado    <= nxt_s;
    end
  end

endmodule
